// File: rtl/debounce_ped_pkg.sv
// rtl/debounce_ped_pkg.sv - shared state encoding and default debounce constants
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b11,
        S_FALL = 2'b10
    } state_e;

    // 5 ms at 100 MHz for the board; a short count keeps simulation fast
    localparam int unsigned DB_COUNT_BOARD = 500000;
    localparam int unsigned CNT_W_BOARD    = 19;
    localparam int unsigned DB_COUNT_SIM   = 4;
    localparam int unsigned CNT_W_SIM      = 3;

endpackage

// File: rtl/debounce_ped_sync_2ff.sv
// rtl/debounce_ped_sync_2ff.sv - two-flop synchroniser, async active-low reset
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            s1_q <= d_i;
            s_q  <= s1_q;
        end
    end

    assign q_o = s_q;

endmodule

// File: rtl/debounce_ped.sv
// rtl/debounce_ped.sv - button debouncer with press pulse; DEBOUNCE_NED_EN adds release pulse ned
module debounce_ped
    import debounce_pkg::*;
#(
    parameter int unsigned DB_COUNT = DB_COUNT_BOARD,
    parameter int unsigned CNT_W    = CNT_W_BOARD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic ped
`ifdef DEBOUNCE_NED_EN
    ,
    output logic ned
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ped_q, ped_d;
`ifdef DEBOUNCE_NED_EN
    logic             ned_q, ned_d;
`endif

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_in),
        .q_o   (s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ped_d   = 1'b0;
`ifdef DEBOUNCE_NED_EN
        ned_d   = 1'b0;
`endif
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_RISE;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_RISE: begin
                // any low sample restarts qualification from zero
                if (!s) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                    ped_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_FALL;
                end else begin
                    cnt_d   = '0;
                end
            end
            S_FALL: begin
                if (s) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOW;
`ifdef DEBOUNCE_NED_EN
                    ned_d   = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            ped_q   <= 1'b0;
`ifdef DEBOUNCE_NED_EN
            ned_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ped_q   <= ped_d;
`ifdef DEBOUNCE_NED_EN
            ned_q   <= ned_d;
`endif
        end
    end

    // the encoding puts the debounced level in the state MSB
    assign db_level = state_q[1];
    assign ped      = ped_q;
`ifdef DEBOUNCE_NED_EN
    assign ned      = ned_q;
`endif

endmodule

// File: tb/tb_debounce_ped.sv
// tb/tb_debounce_ped.sv - directed and randomized bench against a run-length reference model
module tb_debounce_ped;

    localparam int DB = 4;

    logic clk;
    logic reset;
    logic btn_in;
    logic db_level;
    logic ped;
`ifdef DEBOUNCE_NED_EN
    logic ned;
`endif

    int vectors;
    int miscompares;
    int ped_count;

    // reference model: s is btn_in delayed two edges; the level flips once
    // DB consecutive observed samples disagree with it
    logic m_s1, m_s, m_level, m_ped, m_ned;
    int   m_run;

    debounce_ped #(.DB_COUNT(DB), .CNT_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_in   (btn_in),
        .db_level (db_level),
        .ped      (ped)
`ifdef DEBOUNCE_NED_EN
        ,
        .ned      (ned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_s1 = 1'b0; m_s = 1'b0; m_level = 1'b0;
        m_ped = 1'b0; m_ned = 1'b0; m_run = 0;
    endtask

    task automatic tick(input logic b);
        logic obs;
        btn_in = b;
        @(posedge clk);
        if (!reset) begin
            model_clear();
        end else begin
            obs   = m_s;
            m_s   = m_s1;
            m_s1  = b;
            m_ped = 1'b0;
            m_ned = 1'b0;
            if (obs != m_level) begin
                m_run++;
                if (m_run == DB) begin
                    m_level = ~m_level;
                    m_run   = 0;
                    m_ped   = m_level;
                    m_ned   = ~m_level;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        chk("db_level", int'(db_level), int'(m_level));
        chk("ped", int'(ped), int'(m_ped));
`ifdef DEBOUNCE_NED_EN
        chk("ned", int'(ned), int'(m_ned));
`endif
        if (ped === 1'b1) ped_count++;
    endtask

    initial begin
        int first;
        int start_peds;
        int rose;
        logic [7:0] bounce;
        vectors     = 0;
        miscompares = 0;
        ped_count   = 0;
        model_clear();
        reset  = 1'b0;
        btn_in = 1'b0;

        #1;
        chk("reset_db_level", int'(db_level), 0);
        chk("reset_ped", int'(ped), 0);
        for (int i = 0; i < 3; i++) tick(1'b0);

        // clean press: btn high before edge 0
        reset = 1'b1;
        for (int i = 0; i < 6; i++) tick(1'b1);
        chk("press_db_level_e5", int'(db_level), 1);
        chk("press_ped_e5", int'(ped), 1);
        tick(1'b1);
        chk("press_ped_e6", int'(ped), 0);
        chk("press_hold_level", int'(db_level), 1);
        for (int i = 0; i < 10; i++) tick(1'b1);
        chk("press_single_ped", ped_count, 1);

        // release: level falls after edge 5, no ped
        first = -1;
        start_peds = ped_count;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0);
            if (db_level === 1'b0 && first < 0) first = i;
        end
        chk("release_edge", first, 5);
        chk("release_no_ped", ped_count - start_peds, 0);

        // bounce rejection: final rising edge before edge 3 -> ped after edge 8
        bounce = 8'b1111_1011;
        first  = -1;
        for (int i = 0; i < 14; i++) begin
            tick(i < 8 ? bounce[i] : 1'b1);
            if (ped === 1'b1 && first < 0) first = i;
        end
        chk("bounce_ped_edge", first, 8);
        for (int i = 0; i < 10; i++) tick(1'b0);

        // short glitch never qualifies
        start_peds = ped_count;
        rose = 0;
        for (int i = 0; i < 12; i++) begin
            tick(i < 3 ? 1'b1 : 1'b0);
            if (db_level === 1'b1) rose = 1;
        end
        chk("glitch_no_ped", ped_count - start_peds, 0);
        chk("glitch_no_level", rose, 0);

        // reset while in S_RISE with count 2
        for (int i = 0; i < 4; i++) tick(1'b1);
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_rise_level", int'(db_level), 0);
        chk("rst_rise_ped", int'(ped), 0);
        tick(1'b1);
        tick(1'b1);
        reset = 1'b1;
        first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1);
            if (ped === 1'b1 && first < 0) first = i;
        end
        chk("rst_release_ped_edge", first, 5);

        // reset while debounced high drops the level at once
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_high_level", int'(db_level), 0);
        tick(1'b1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b0);

        // randomized bounce and hold segments
        for (int r = 0; r < 60; r++) begin
            int nb = $urandom_range(0, 6);
            logic v = 1'($urandom_range(0, 1));
            int nh = $urandom_range(0, 9);
            for (int i = 0; i < nb; i++) tick(1'($urandom_range(0, 1)));
            for (int i = 0; i < nh; i++) tick(v);
        end
        for (int i = 0; i < 10; i++) tick(1'b0);

        // three heavily bounced presses produce exactly three peds
        start_peds = ped_count;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 10; i++) tick(1'($urandom_range(0, 1)));
            for (int i = 0; i < 8; i++) tick(1'b1);
            for (int i = 0; i < 10; i++) tick(1'($urandom_range(0, 1)));
            for (int i = 0; i < 8; i++) tick(1'b0);
        end
        chk("integration_count", ped_count - start_peds, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
